// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty decoder: default code width, period derivation, FSM encoding.
package pwm_pkg;

  localparam int DUTY_W_DEF = 4;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    MEASURE = 2'd1,
    LOST    = 2'd2
  } pwm_state_t;

  // One PWM period spans 2**duty_w clocks.
  function automatic int pwm_period(input int duty_w);
    return 1 << duty_w;
  endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Input register chain plus edge detect; depth 2 (synchronizer) with PWM_DECODER_SYNC_EN, else 1.
// Pure pipeline, no backpressure; s_prev clears to 0 so an input held high through reset reads as a rise.
module pwm_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pwm,
  output logic o_s_in,
  output logic o_rise,
  output logic o_fall
);

  logic r_sync;
  logic r_prev;

`ifdef PWM_DECODER_SYNC_EN
  logic r_meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_pwm;
      r_sync <= r_meta;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 1'b0;
    end else begin
      r_sync <= i_pwm;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= r_sync;
    end
  end

  assign o_s_in = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/pwm_duty_decoder.sv
// Recovers the duty code (high clocks per 2**DUTY_W-clock period, 0 = 100%) from a PWM input.
// Latency 1 clock, or 2 with PWM_DECODER_SYNC_EN; free-running, no backpressure, all outputs registered.
module pwm_duty_decoder
  import pwm_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              duty_valid,
  output logic              sample_stb,
  output logic              period_err,
  output logic              signal_lost
);

  localparam int               CNT_W    = DUTY_W + 1;
  localparam logic [CNT_W-1:0] L_PERIOD = CNT_W'(pwm_period(DUTY_W));
  localparam logic [CNT_W-1:0] L_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_LAST   = L_PERIOD - L_ONE;

  logic w_s_in;
  logic w_rise;
  logic w_fall;
  logic w_low_trip;

  pwm_state_t        r_state;
  logic [CNT_W-1:0]  r_period_cnt;
  logic [CNT_W-1:0]  r_high_cnt;
  logic [CNT_W-1:0]  r_low_cnt;
  logic [DUTY_W-1:0] r_duty;
  logic              r_valid;
  logic              r_stb;
  logic              r_err;
  logic              r_lost;

  pwm_state_t        w_state_nxt;
  logic [CNT_W-1:0]  w_period_nxt;
  logic [CNT_W-1:0]  w_high_nxt;
  logic [CNT_W-1:0]  w_low_nxt;
  logic [DUTY_W-1:0] w_duty_nxt;
  logic              w_valid_nxt;
  logic              w_stb_nxt;
  logic              w_err_nxt;
  logic              w_lost_nxt;

  pwm_edge_sync u_edge_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_pwm  (pwm_in),
    .o_s_in (w_s_in),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // Sixteenth consecutive low clock is being seen this cycle.
  assign w_low_trip = ~w_s_in & (r_low_cnt == L_LAST);

  always_comb begin
    w_state_nxt  = r_state;
    w_period_nxt = r_period_cnt;
    w_high_nxt   = r_high_cnt;
    w_low_nxt    = r_low_cnt;
    w_duty_nxt   = r_duty;
    w_valid_nxt  = r_valid;
    w_stb_nxt    = 1'b0;
    w_err_nxt    = 1'b0;
    w_lost_nxt   = r_lost;

    if (w_s_in) begin
      w_low_nxt = '0;
    end else if (w_fall) begin
      w_low_nxt = L_ONE;
    end else if (r_low_cnt != L_PERIOD) begin
      w_low_nxt = r_low_cnt + L_ONE;
    end

    case (r_state)
      ACQUIRE: begin
        if (w_rise) begin
          w_state_nxt  = MEASURE;
          w_period_nxt = L_ONE;
          w_high_nxt   = L_ONE;
        end
      end

      MEASURE: begin
        if (w_rise) begin
          if (r_period_cnt == L_PERIOD) begin
            w_duty_nxt  = r_high_cnt[DUTY_W-1:0];
            w_valid_nxt = 1'b1;
            w_stb_nxt   = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
          w_period_nxt = L_ONE;
          w_high_nxt   = L_ONE;
        end else if (w_s_in && (r_high_cnt == L_PERIOD)) begin
          // A full period high with no edge is the 100% code.
          w_duty_nxt   = '0;
          w_valid_nxt  = 1'b1;
          w_stb_nxt    = 1'b1;
          w_period_nxt = L_ONE;
          w_high_nxt   = L_ONE;
        end else begin
          if (r_period_cnt != L_PERIOD) begin
            w_period_nxt = r_period_cnt + L_ONE;
          end
          if (w_s_in && (r_high_cnt != L_PERIOD)) begin
            w_high_nxt = r_high_cnt + L_ONE;
          end
        end
      end

      LOST: begin
        if (w_rise) begin
          w_state_nxt  = MEASURE;
          w_lost_nxt   = 1'b0;
          w_period_nxt = L_ONE;
          w_high_nxt   = L_ONE;
        end
      end

      default: begin
        w_state_nxt = ACQUIRE;
      end
    endcase

    if (w_low_trip) begin
      w_state_nxt = LOST;
      w_lost_nxt  = 1'b1;
      w_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ACQUIRE;
      r_period_cnt <= '0;
      r_high_cnt   <= '0;
      r_low_cnt    <= '0;
      r_duty       <= '0;
      r_valid      <= 1'b0;
      r_stb        <= 1'b0;
      r_err        <= 1'b0;
      r_lost       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_period_cnt <= w_period_nxt;
      r_high_cnt   <= w_high_nxt;
      r_low_cnt    <= w_low_nxt;
      r_duty       <= w_duty_nxt;
      r_valid      <= w_valid_nxt;
      r_stb        <= w_stb_nxt;
      r_err        <= w_err_nxt;
      r_lost       <= w_lost_nxt;
    end
  end

  assign duty_cycle  = r_duty;
  assign duty_valid  = r_valid;
  assign sample_stb  = r_stb;
  assign period_err  = r_err;
  assign signal_lost = r_lost;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Bench for pwm_duty_decoder: table of PWM segments plus hand sequences, events checked by a scoreboard.
module tb_pwm_duty_decoder;

`ifdef PWM_DECODER_SYNC_EN
  localparam int N = 2;
`else
  localparam int N = 1;
`endif

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b1;
  logic       pwm_in = 1'b0;
  logic [3:0] duty_cycle;
  logic       duty_valid;
  logic       sample_stb;
  logic       period_err;
  logic       signal_lost;

  pwm_duty_decoder #(.DUTY_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pwm_in      (pwm_in),
    .duty_cycle  (duty_cycle),
    .duty_valid  (duty_valid),
    .sample_stb  (sample_stb),
    .period_err  (period_err),
    .signal_lost (signal_lost)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [3:0] duty;
    int         cyc;
  } ev_t;

  typedef struct {
    int         high;
    int         period;
    int         nper;
    logic [3:0] exp_duty;
    logic       exp_valid;
  } vec_t;

  ev_t  sb[$];
  ev_t  ev;
  vec_t vecs[6];

  int n_checks = 0;
  int n_fail   = 0;
  int last_r   = -1;
  int last_high = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a rise closes the previous period, whose result appears N edges after the rise is sampled.
  task automatic note_rise(input int r, input int high);
    ev_t e;
    if (last_r >= 0) begin
      e.is_err = ((r - last_r) != 16);
      e.duty   = e.is_err ? 4'd0 : 4'(last_high);
      e.cyc    = r + N;
      sb.push_back(e);
    end
    last_r    = r;
    last_high = high;
  endtask

  task automatic drive_seg(input int high, input int period, input int start, input int stop);
    for (int i = start; i < stop; i++) begin
      @(posedge clk); #1;
      if (i == 0 && high > 0) note_rise(cyc + 1, high);
      pwm_in = (i < high);
    end
  endtask

  task automatic drive_period(input int high, input int period);
    drive_seg(high, period, 0, period);
  endtask

  // Constant high for nclk clocks: 100% strobes every 16 clocks after the entering rise.
  task automatic drive_const(input int nclk);
    ev_t e;
    int  r;
    @(posedge clk); #1;
    r = cyc + 1;
    note_rise(r, 0);
    for (int k = 1; 16 * k <= nclk - 1; k++) begin
      e.is_err = 1'b0;
      e.duty   = 4'd0;
      e.cyc    = r + 16 * k + N;
      sb.push_back(e);
    end
    pwm_in = 1'b1;
    repeat (nclk - 1) begin
      @(posedge clk); #1;
    end
    last_r = -1;
  endtask

  task automatic wait_edge(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && (sample_stb || period_err)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: stb=%0b err=%0b duty=%0d at cycle %0d, none expected",
                 sample_stb, period_err, duty_cycle, cyc);
      end else begin
        ev = sb.pop_front();
        chk("event_kind", int'({sample_stb, period_err}), ev.is_err ? 1 : 2);
        chk("event_cycle", cyc, ev.cyc);
        if (!ev.is_err) chk("event_duty", int'(duty_cycle), int'(ev.duty));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int f;

    vecs[0] = '{1, 16, 19, 4'h1, 1'b1};
    vecs[1] = '{8, 16, 3, 4'h8, 1'b1};
    vecs[2] = '{15, 16, 3, 4'hF, 1'b1};
    vecs[3] = '{6, 12, 4, 4'hF, 1'b1};
    vecs[4] = '{3, 16, 3, 4'h3, 1'b1};
    vecs[5] = '{13, 16, 2, 4'hD, 1'b1};

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_duty_cycle", int'(duty_cycle), 0);
    chk("reset_duty_valid", int'(duty_valid), 0);
    chk("reset_sample_stb", int'(sample_stb), 0);
    chk("reset_period_err", int'(period_err), 0);
    chk("reset_signal_lost", int'(signal_lost), 0);
    @(posedge clk); #2 rst_n = 1'b1;

    drive_period(1, 16);
    chk("valid_before_2nd_rise", int'(duty_valid), 0);

    for (int v = 0; v < 6; v++) begin
      for (int p = 0; p < vecs[v].nper; p++) drive_period(vecs[v].high, vecs[v].period);
      @(negedge clk);
      chk($sformatf("seg%0d_duty", v), int'(duty_cycle), int'(vecs[v].exp_duty));
      chk($sformatf("seg%0d_valid", v), int'(duty_valid), int'(vecs[v].exp_valid));
      chk($sformatf("seg%0d_lost", v), int'(signal_lost), 0);
    end

    // Constant high, then held low until the signal is declared lost.
    drive_const(72);
    chk("const_duty", int'(duty_cycle), 0);
    chk("const_valid", int'(duty_valid), 1);
    @(posedge clk); #1 pwm_in = 1'b0;
    f = cyc + 1;
    wait_edge(f + 14 + N);
    chk("lost_not_yet_15_lows", int'(signal_lost), 0);
    chk("valid_before_lost", int'(duty_valid), 1);
    wait_edge(f + 15 + N);
    chk("lost_at_16_lows", int'(signal_lost), 1);
    chk("lost_clears_valid", int'(duty_valid), 0);
    chk("lost_holds_duty", int'(duty_cycle), 0);

    last_r = -1;
    drive_period(5, 16);
    chk("recover_lost_cleared", int'(signal_lost), 0);
    chk("recover_valid_still_0", int'(duty_valid), 0);
    drive_period(5, 16);
    drive_period(5, 16);
    chk("recover_duty", int'(duty_cycle), 5);
    chk("recover_valid", int'(duty_valid), 1);

    // Reset in the high phase of a duty-8 period; input stays high through release.
    drive_period(8, 16);
    drive_period(8, 16);
    drive_seg(8, 16, 0, 6);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_duty_cycle", int'(duty_cycle), 0);
    chk("midreset_duty_valid", int'(duty_valid), 0);
    chk("midreset_sample_stb", int'(sample_stb), 0);
    chk("midreset_period_err", int'(period_err), 0);
    chk("midreset_signal_lost", int'(signal_lost), 0);
    chk("midreset_no_pending", sb.size(), 0);
    sb.delete();
    last_r = -1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    note_rise(cyc + 1, 8);
    drive_seg(8, 16, 1, 16);
    @(negedge clk);
    chk("postreset_valid_first_period", int'(duty_valid), 0);
    for (int p = 0; p < 3; p++) drive_period(8, 16);
    @(negedge clk);
    chk("postreset_duty", int'(duty_cycle), 8);
    chk("postreset_valid", int'(duty_valid), 1);

    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
